// File: rtl/tri_bus_arbiter_pkg.sv
// tri_bus_arbiter_pkg: shared types and width helpers for the tri-state bus arbiter.
//   arb_state_e : FSM state encoding (IDLE / GRANT / TURN)
//   HOLD_W      : width of the per-tenure hold counter (saturates at 255)
//   TURN_W      : width of the turnaround counter (TURNAROUND <= 3)
//   idx_w()     : index width for N requesters (at least 1 bit)
package tri_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    TURN  = 2'b10
  } arb_state_e;

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned TURN_W = 2;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// tri_bus_arbiter_rr_pick: combinational round-robin selector.
//   req   : request vector
//   last  : index of the previous owner (lowest priority this round)
//   valid : at least one request is set
//   pick  : first set request searching last+1, last+2, ... modulo N_REQ
module tri_bus_arbiter_rr_pick
  import tri_bus_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             valid,
  output logic [IW-1:0]    pick
);

  logic [IW-1:0] cand;

  // k = N_REQ wraps back to last itself, so a sole requester is still found
  always_comb begin
    valid = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IW'((32'(last) + k) % N_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        pick  = cand;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter: round-robin arbiter for a shared tri-state bus. Grants are
// registered, one-hot or zero, and separated by an all-zero turnaround gap so
// two TRI drivers never overlap.
//   clk      : rising-edge clock
//   reset    : synchronous, active-high reset
//   req      : level-sensitive request per requester
//   done     : release pulse from the current owner (other bits ignored)
//   grant    : one-hot or zero, drives the TRI cntl inputs
//   bus_busy : high while a tenure is in progress
//   owner    : index of the current / last owner
//   timeout  : one-cycle pulse after a forced release
// Build option: define TRI_ARB_HOLD_LIMIT_EN to cap each tenure at MAX_HOLD
// grant cycles; without it the owner keeps the bus until req drops or done.
module tri_bus_arbiter
  import tri_bus_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ      = 4,
  parameter  int unsigned MAX_HOLD   = 8,
  parameter  int unsigned TURNAROUND = 1,
  localparam int unsigned IW         = idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic             bus_busy,
  output logic [IW-1:0]    owner,
  output logic             timeout
);

  // Elaboration-time guard on legal parameter ranges
  if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 2 || MAX_HOLD > 255 ||
      TURNAROUND < 1 || TURNAROUND > 3) begin : g_param_check
    $error("tri_bus_arbiter: parameter out of legal range");
  end

  arb_state_e        state, state_nxt;
  logic [N_REQ-1:0]  grant_nxt;
  logic              busy_nxt;
  logic [IW-1:0]     owner_nxt;
  logic [IW-1:0]     last, last_nxt;
  logic [TURN_W-1:0] turn_cnt, turn_nxt;
  logic              pick_valid;
  logic [IW-1:0]     pick;
  logic              release_c;
  logic              forced_c;

  tri_bus_arbiter_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .pick  (pick)
  );

`ifdef TRI_ARB_HOLD_LIMIT_EN
  logic [HOLD_W-1:0] hold;

  // Forced release only while the owner still wants the bus
  assign forced_c = (state == GRANT) && (hold == HOLD_W'(MAX_HOLD)) &&
                    req[owner] && !done[owner];

  // Hold counter and timeout pulse; timeout lands on the first TURN cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      hold    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= forced_c;
      if (state == IDLE && pick_valid) begin
        hold <= HOLD_W'(1);
      end else if (state == GRANT && !release_c && hold != '1) begin
        hold <= HOLD_W'(hold + 1'b1);
      end
    end
  end
`else
  assign forced_c = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Voluntary (req dropped or done) or forced release of the current owner
  assign release_c = !req[owner] || done[owner] || forced_c;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      bus_busy <= 1'b0;
      owner    <= '0;
      last     <= IW'(N_REQ - 1);
      turn_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      bus_busy <= busy_nxt;
      owner    <= owner_nxt;
      last     <= last_nxt;
      turn_cnt <= turn_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    busy_nxt  = bus_busy;
    owner_nxt = owner;
    last_nxt  = last;
    turn_nxt  = turn_cnt;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt       = GRANT;
          grant_nxt       = '0;
          grant_nxt[pick] = 1'b1;
          busy_nxt        = 1'b1;
          owner_nxt       = pick;
          last_nxt        = pick;
        end
      end
      GRANT: begin
        if (release_c) begin
          state_nxt = TURN;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          turn_nxt  = TURN_W'(TURNAROUND);
        end
      end
      TURN: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        turn_nxt  = TURN_W'(turn_cnt - 1'b1);
        // Leave on the last turnaround cycle; IDLE then adds the arbitration cycle
        if (turn_cnt <= TURN_W'(1)) begin
          state_nxt = IDLE;
          turn_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        turn_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb_tri_bus_arbiter: directed bench for tri_bus_arbiter with a behavioural
// tenure/gap model checked every cycle, plus literal expectations per scenario.
// Instance a uses TURNAROUND=1, instance b uses TURNAROUND=3.
module tb_tri_bus_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned MAXH = 8;
  localparam int unsigned IW   = 2;
`ifdef TRI_ARB_HOLD_LIMIT_EN
  localparam bit HL = 1'b1;
`else
  localparam bit HL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_a, done_a, grant_a, req_b, done_b, grant_b;
  logic          busy_a, busy_b, tmo_a, tmo_b;
  logic [IW-1:0] owner_a, owner_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tri_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH), .TURNAROUND(1)) u_ta1 (
    .clk(clk), .reset(reset), .req(req_a), .done(done_a),
    .grant(grant_a), .bus_busy(busy_a), .owner(owner_a), .timeout(tmo_a)
  );

  tri_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH), .TURNAROUND(3)) u_ta3 (
    .clk(clk), .reset(reset), .req(req_b), .done(done_b),
    .grant(grant_b), .bus_busy(busy_b), .owner(owner_b), .timeout(tmo_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: tenures, gaps, round-robin order -----
  bit            started = 1'b0;
  bit            m_busy  [2];
  logic [IW-1:0] m_owner [2];
  logic [IW-1:0] m_last  [2];
  int            m_hold  [2];
  int            m_gap   [2];
  bit            m_tmo   [2];
  logic [N-1:0]  mr, md;
  logic [IW-1:0] mc;
  bit            mforced;

  function automatic int ta(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  always @(posedge clk) begin
    if (reset) started = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mr = (k == 0) ? req_a : req_b;
      md = (k == 0) ? done_a : done_b;
      if (reset) begin
        m_busy[k] = 1'b0; m_owner[k] = '0; m_last[k] = IW'(N - 1);
        m_hold[k] = 0; m_gap[k] = 0; m_tmo[k] = 1'b0;
      end else begin
        m_tmo[k] = 1'b0;
        if (m_busy[k]) begin
          mforced = HL && (m_hold[k] == MAXH) && mr[m_owner[k]] && !md[m_owner[k]];
          if (!mr[m_owner[k]] || md[m_owner[k]] || mforced) begin
            m_busy[k] = 1'b0;
            m_gap[k]  = ta(k);
            m_tmo[k]  = mforced;
          end else if (m_hold[k] < 255) begin
            m_hold[k]++;
          end
        end else if (m_gap[k] > 0) begin
          m_gap[k]--;
        end else begin
          for (int s = 1; s <= int'(N); s++) begin
            mc = IW'((int'(m_last[k]) + s) % N);
            if (!m_busy[k] && mr[mc]) begin
              m_busy[k] = 1'b1; m_owner[k] = mc; m_last[k] = mc; m_hold[k] = 1;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ---------------------
  logic [N-1:0]  c_g, c_exp;
  logic          c_b, c_t;
  logic [IW-1:0] c_o;

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        c_g = (k == 0) ? grant_a : grant_b;
        c_b = (k == 0) ? busy_a  : busy_b;
        c_t = (k == 0) ? tmo_a   : tmo_b;
        c_o = (k == 0) ? owner_a : owner_b;
        c_exp = '0;
        if (m_busy[k]) c_exp[m_owner[k]] = 1'b1;
        check((k == 0) ? "model_grant_a" : "model_grant_b", 32'(c_g), 32'(c_exp));
        check((k == 0) ? "model_busy_a" : "model_busy_b", 32'(c_b), 32'(m_busy[k]));
        check((k == 0) ? "model_owner_a" : "model_owner_b", 32'(c_o), 32'(m_owner[k]));
        check((k == 0) ? "model_tmo_a" : "model_tmo_b", 32'(c_t), 32'(m_tmo[k]));
        check("onehot", 32'($countones(c_g) <= 1), 32'd1);
        check("busy_iff_grant", 32'(c_b), 32'(|c_g));
      end
    end
  end

  // ---------------- directed stimulus ---------------------------------------
  logic [N-1:0]  s2_req [11] = '{4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0100,
                                 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
  logic [N-1:0]  s2_exp [11] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                                 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
  logic [IW-1:0] s2_own [11] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                                 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
  logic [IW-1:0] s3_own [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  int            own_seq [5];
  int            gap_seq [5];
  int            tenures, run, zeros;
  logic [N-1:0]  prev;

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    req_a = '0; done_a = '0; req_b = '0; done_b = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_a = '0; done_a = '0; req_b = '0; done_b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    repeat (5) begin
      @(negedge clk);
      check("idle_grant", 32'(grant_a), 32'd0);
      check("idle_busy", 32'(busy_a), 32'd0);
      check("idle_owner", 32'(owner_a), 32'd0);
      check("idle_timeout", 32'(tmo_a), 32'd0);
    end

    // Two requesters each dropping req after 3 grant cycles
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check("drop_grant", 32'(grant_a), 32'(s2_exp[i]));
      check("drop_owner", 32'(owner_a), 32'(s2_own[i]));
      req_a = s2_req[i];
    end

    // All requesting, done pulsed on the 2nd grant cycle of each tenure
    pulse_reset();
    req_a = 4'b1111;
    tenures = 0; run = 0; zeros = 0; prev = '0;
    for (int c = 0; c < 60 && tenures < 5; c++) begin
      @(negedge clk);
      if (grant_a != '0) begin
        if (grant_a != prev) begin
          own_seq[tenures] = int'(owner_a);
          if (tenures > 0) gap_seq[tenures-1] = zeros;
          tenures++;
          run = 1;
          zeros = 0;
        end else begin
          run++;
        end
        done_a = (run == 2) ? grant_a : '0;
      end else begin
        done_a = '0;
        zeros++;
      end
      prev = grant_a;
    end
    check("rr_tenures", 32'(tenures), 32'd5);
    for (int i = 0; i < 5; i++) check("rr_owner_order", 32'(own_seq[i]), 32'(s3_own[i]));
    for (int i = 0; i < 4; i++) check("rr_gap", 32'(gap_seq[i]), 32'd2);
    done_a = '0;

    // Sole requester held high: hold limit behaviour (or none)
    pulse_reset();
    req_a = 4'b0001;
    @(negedge clk);
`ifdef TRI_ARB_HOLD_LIMIT_EN
    for (int t = 0; t < 2; t++) begin
      run = 0;
      while (grant_a == 4'b0001 && run < 300) begin
        run++;
        @(negedge clk);
      end
      check("hold_len", 32'(run), 32'(MAXH));
      check("timeout_pulse", 32'(tmo_a), 32'd1);
      zeros = 0;
      while (grant_a == 4'b0000 && zeros < 20) begin
        zeros++;
        if (zeros == 2) check("timeout_one_cycle", 32'(tmo_a), 32'd0);
        @(negedge clk);
      end
      check("regrant_gap", 32'(zeros), 32'd2);
      check("regrant_grant", 32'(grant_a), 32'b0001);
    end
`else
    check("nolimit_first", 32'(grant_a), 32'b0001);
    repeat (20) @(negedge clk);
    check("nolimit_grant", 32'(grant_a), 32'b0001);
    check("nolimit_tmo", 32'(tmo_a), 32'd0);
`endif

    // Reset on the 3rd cycle of a tenure for requester 2
    pulse_reset();
    req_a = 4'b0100;
    repeat (3) @(negedge clk);
    check("pre_reset_grant", 32'(grant_a), 32'b0100);
    reset = 1'b1;
    req_a = 4'b0101;
    @(negedge clk);
    check("reset_grant", 32'(grant_a), 32'd0);
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_owner", 32'(owner_a), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_grant", 32'(grant_a), 32'b0001);
    check("post_reset_owner", 32'(owner_a), 32'd0);

    // TURNAROUND=3: done from owner 0 gives 4 zero-grant cycles
    pulse_reset();
    req_b = 4'b0011;
    @(negedge clk);
    check("ta3_first", 32'(grant_b), 32'b0001);
    done_b = 4'b0001;
    @(negedge clk);
    done_b = '0;
    zeros = 0;
    while (grant_b == 4'b0000 && zeros < 20) begin
      zeros++;
      @(negedge clk);
    end
    check("ta3_gap", 32'(zeros), 32'd4);
    check("ta3_next", 32'(grant_b), 32'b0010);

    req_a = '0; req_b = '0;
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
